// File: rtl/rng2d_pkg.sv
// Shared types for the 2D PRNG point sampler: default coordinate width,
// point record and sampler FSM states.
package rng2d_pkg;

  localparam int COORD_W_DEF = 8;

  typedef struct packed {
    logic [COORD_W_DEF-1:0] x;
    logic [COORD_W_DEF-1:0] y;
  } point_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/rng_point_sampler_if.sv
// Point output channel of the sampler: valid/ready handshake carrying one (x,y) pair.
interface rng_point_sampler_if
  import rng2d_pkg::*;
#(
  parameter int COORD_W = COORD_W_DEF
);

  logic               pt_valid;
  logic               pt_ready;
  logic [COORD_W-1:0] pt_x;
  logic [COORD_W-1:0] pt_y;

  modport master (output pt_valid, output pt_x, output pt_y, input pt_ready);
  modport slave  (input pt_valid, input pt_x, input pt_y, output pt_ready);

endinterface

// File: rtl/rng_pt_fifo.sv
// Synchronous first-word-visible FIFO; the head entry is held in a register so
// dout is valid in the cycle after the write that made the FIFO non-empty.
module rng_pt_fifo
  import rng2d_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  output logic                     full,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [AW:0]      rd_next;
  logic             push_ok;
  logic             pop_ok;

  // Extra MSB on the pointers separates full (MSBs differ) from empty (equal).
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count   = wr_ptr - rd_ptr;
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign rd_next = rd_ptr + (AW+1)'(pop_ok);

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      dout   <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + (AW+1)'(1);
      rd_ptr <= rd_next;
      // When the new head is the word being written this cycle, bypass the array.
      if (push_ok && (rd_next == wr_ptr)) dout <= din;
      else if (pop_ok)                    dout <= mem[rd_next[AW-1:0]];
    end
  end

endmodule

// File: rtl/rng_point_sampler.sv
// Rejection-samples (x,y) points from the free-running PRNG word and emits exactly
// num_points in-range points per start through a small buffer, then pulses done.
module rng_point_sampler
  import rng2d_pkg::*;
#(
  parameter int COORD_W    = COORD_W_DEF,
  parameter int X_RANGE    = 200,
  parameter int Y_RANGE    = 150,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [15:0]         rnd_data,
  input  logic                start,
  input  logic [CNT_W-1:0]    num_points,
  output logic                busy,
  output logic                done,
  rng_point_sampler_if.master pt,
  output logic [CNT_W-1:0]    reject_cnt
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [COORD_W:0] X_LIM = (COORD_W+1)'(X_RANGE);
  localparam logic [COORD_W:0] Y_LIM = (COORD_W+1)'(Y_RANGE);

  state_t             state;
  logic [CNT_W-1:0]   target;
  logic [CNT_W-1:0]   issued;
  logic [CNT_W-1:0]   issued_inc;
  logic [COORD_W-1:0] cand_x;
  logic [COORD_W-1:0] cand_y;
  logic               in_range;
  logic               fifo_push;
  logic               fifo_pop;
  logic               fifo_full;
  logic               fifo_empty;
  logic [AW:0]        fifo_count;
  logic               drain_empty;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign cand_x   = rnd_data[2*COORD_W-1:COORD_W];
  assign cand_y   = rnd_data[COORD_W-1:0];
  assign in_range = ({1'b0, cand_x} < X_LIM) && ({1'b0, cand_y} < Y_LIM);

  // The pre-pop full flag gates the push: a full buffer drops the candidate even if it pops.
  assign fifo_push  = (state == RUN) && in_range && !fifo_full;
  assign fifo_pop   = pt.pt_valid && pt.pt_ready;
  assign issued_inc = issued + CNT_W'(1);

  // Nothing is pushed in DRAIN, so the buffer is empty after this edge when it
  // already is, or when the only remaining entry is popped now.
  assign drain_empty = fifo_empty || (fifo_pop && (fifo_count == (AW+1)'(1)));

  assign pt.pt_valid = !fifo_empty;

  rng_pt_fifo #(
    .WIDTH (2*COORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .din   ({cand_x, cand_y}),
    .full  (fifo_full),
    .pop   (fifo_pop),
    .dout  ({pt.pt_x, pt.pt_y}),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      target     <= '0;
      issued     <= '0;
      reject_cnt <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            target     <= num_points;
            issued     <= '0;
            reject_cnt <= '0;
            busy       <= 1'b1;
            state      <= (num_points == '0) ? DRAIN : RUN;
          end
        end
        RUN: begin
          if (fifo_push) begin
            issued <= issued_inc;
            if (issued_inc == target) state <= DRAIN;
          end
          if (!in_range) reject_cnt <= sat_inc(reject_cnt);
        end
        DRAIN: begin
          if (drain_empty) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
